// File: rtl/cic_comp_fir.sv
// -----------------------------------------------------------------------------
// cic_comp_fir
//   Serial-MAC FIR that compensates CIC passband droop. It takes the sparse
//   decimated I/Q stream from the CIC and runs one shared multiply-accumulate
//   pass per channel across all NTAPS taps. Coefficients can be written at run
//   time. Out of reset they form an identity filter (coef[0] = 1.0).
//
//   Optional build macro: CIC_COMP_FIR_SATURATE_EN
//     defined   -> rounded result clamps to the WIDTH-bit signed range
//     undefined -> low WIDTH bits of the rounded result (two's-complement wrap)
//
// Ports
//   i_clock, i_reset_n          clock, asynchronous active-low reset
//   i_inph_data, i_quad_data    signed I/Q input samples
//   i_valid                     single-cycle input strobe
//   o_inph_data, o_quad_data    filtered, rounded I/Q results (held between strobes)
//   o_valid                     one-cycle output strobe
//   o_busy                      high while a sample is being processed
//   o_overrun                   sticky: input strobe arrived while busy (sample dropped)
//   i_coef_wr/addr/data         coefficient write port, accepted only when idle
// -----------------------------------------------------------------------------
module cic_comp_fir #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 18,
  parameter int NTAPS      = 16,
  parameter int SHIFT      = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic signed [WIDTH-1:0]       i_inph_data,
  input  logic signed [WIDTH-1:0]       i_quad_data,
  input  logic                          i_valid,
  output logic signed [WIDTH-1:0]       o_inph_data,
  output logic signed [WIDTH-1:0]       o_quad_data,
  output logic                          o_valid,
  output logic                          o_busy,
  output logic                          o_overrun,
  input  logic                          i_coef_wr,
  input  logic [$clog2(NTAPS)-1:0]      i_coef_addr,
  input  logic signed [COEF_WIDTH-1:0]  i_coef_data
);

  localparam int AW    = $clog2(NTAPS);
  localparam int PW    = WIDTH + COEF_WIDTH;
  localparam int ACC_W = PW + AW;

  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE =
    {{(COEF_WIDTH-1){1'b0}}, 1'b1} << SHIFT;
  localparam logic signed [ACC_W:0] RND =
    {{ACC_W{1'b0}}, 1'b1} << (SHIFT-1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Round half toward +inf, then limit to WIDTH bits. One guard bit above the
  // accumulator keeps the rounding add from overflowing.
`ifdef CIC_COMP_FIR_SATURATE_EN
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] round_limit(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] r;
    r = ($signed({acc[ACC_W-1], acc}) + RND) >>> SHIFT;
    if (r > MAXV)      return WIDTH'(MAXV);
    else if (r < MINV) return WIDTH'(MINV);
    else               return WIDTH'(r);
  endfunction
`else
  function automatic logic signed [WIDTH-1:0] round_limit(input logic signed [ACC_W-1:0] acc);
    return WIDTH'(($signed({acc[ACC_W-1], acc}) + RND) >>> SHIFT);
  endfunction
`endif

  state_t                         state_q, state_d;
  logic [AW-1:0]                  tap_q, tap_d;
  logic signed [ACC_W-1:0]        acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [WIDTH-1:0]        x_i_q [NTAPS];
  logic signed [WIDTH-1:0]        x_i_d [NTAPS];
  logic signed [WIDTH-1:0]        x_q_q [NTAPS];
  logic signed [WIDTH-1:0]        x_q_d [NTAPS];
  logic signed [COEF_WIDTH-1:0]   coef_q [NTAPS];
  logic signed [COEF_WIDTH-1:0]   coef_d [NTAPS];
  logic signed [WIDTH-1:0]        out_i_q, out_i_d, out_q_q, out_q_d;
  logic                           valid_q, valid_d;
  logic                           overrun_q, overrun_d;
  logic signed [PW-1:0]           prod_i, prod_q;

  // Single shared multiplier per channel, stepped by the tap counter.
  assign prod_i = PW'(x_i_q[tap_q]) * PW'(coef_q[tap_q]);
  assign prod_q = PW'(x_q_q[tap_q]) * PW'(coef_q[tap_q]);

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    acc_i_d   = acc_i_q;
    acc_q_d   = acc_q_q;
    x_i_d     = x_i_q;
    x_q_d     = x_q_q;
    coef_d    = coef_q;
    out_i_d   = out_i_q;
    out_q_d   = out_q_q;
    valid_d   = 1'b0;
    // A strobe while busy is dropped; only the sticky flag records it.
    overrun_d = overrun_q | (i_valid && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        // A write on the same edge as a new sample is still accepted.
        if (i_coef_wr && (int'(i_coef_addr) < NTAPS))
          coef_d[i_coef_addr] = i_coef_data;
        if (i_valid) begin
          for (int t = NTAPS-1; t > 0; t--) begin
            x_i_d[t] = x_i_q[t-1];
            x_q_d[t] = x_q_q[t-1];
          end
          x_i_d[0] = i_inph_data;
          x_q_d[0] = i_quad_data;
          acc_i_d  = '0;
          acc_q_d  = '0;
          tap_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_i_d = acc_i_q + {{AW{prod_i[PW-1]}}, prod_i};
        acc_q_d = acc_q_q + {{AW{prod_q[PW-1]}}, prod_q};
        if (tap_q == AW'(NTAPS-1)) state_d = OUT;
        else                       tap_d   = tap_q + 1'b1;
      end
      OUT: begin
        out_i_d = round_limit(acc_i_q);
        out_q_d = round_limit(acc_q_q);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      out_i_q   <= '0;
      out_q_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int t = 0; t < NTAPS; t++) begin
        x_i_q[t]  <= '0;
        x_q_q[t]  <= '0;
        coef_q[t] <= (t == 0) ? COEF_ONE : '0;
      end
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      out_i_q   <= out_i_d;
      out_q_q   <= out_q_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      x_i_q     <= x_i_d;
      x_q_q     <= x_q_d;
      coef_q    <= coef_d;
    end
  end

  assign o_inph_data = out_i_q;
  assign o_quad_data = out_q_q;
  assign o_valid     = valid_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cic_comp_fir.sv
// -----------------------------------------------------------------------------
// tb_cic_comp_fir
//   Self-checking bench for cic_comp_fir. Expected results are pushed to a
//   queue when a sample is driven and popped when o_valid is observed.
// -----------------------------------------------------------------------------
module tb_cic_comp_fir;
  localparam int WIDTH      = 16;
  localparam int COEF_WIDTH = 18;
  localparam int NTAPS      = 16;
  localparam int SHIFT      = 16;
  localparam int AW         = $clog2(NTAPS);

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic signed [WIDTH-1:0]       i_inph_data, i_quad_data;
  logic                          i_valid;
  logic signed [WIDTH-1:0]       o_inph_data, o_quad_data;
  logic                          o_valid, o_busy, o_overrun;
  logic                          i_coef_wr;
  logic [AW-1:0]                 i_coef_addr;
  logic signed [COEF_WIDTH-1:0]  i_coef_data;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;

  logic signed [WIDTH-1:0] exp_i[$];
  logic signed [WIDTH-1:0] exp_q[$];

  cic_comp_fir #(
    .WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .NTAPS(NTAPS), .SHIFT(SHIFT)
  ) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_inph_data (i_inph_data),
    .i_quad_data (i_quad_data),
    .i_valid     (i_valid),
    .o_inph_data (o_inph_data),
    .o_quad_data (o_quad_data),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun),
    .i_coef_wr   (i_coef_wr),
    .i_coef_addr (i_coef_addr),
    .i_coef_data (i_coef_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_valid === 1'b1) vcount++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_valid = 1'b0; i_inph_data = '0; i_quad_data = '0;
    i_coef_wr = 1'b0; i_coef_addr = '0; i_coef_data = '0;
    exp_i.delete(); exp_q.delete();
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // Drives one input strobe (sampled at the next edge) and records its expected result.
  task automatic send(input logic signed [WIDTH-1:0] i, input logic signed [WIDTH-1:0] q,
                      input logic signed [WIDTH-1:0] ei, input logic signed [WIDTH-1:0] eq);
    i_inph_data = i; i_quad_data = q; i_valid = 1'b1;
    exp_i.push_back(ei); exp_q.push_back(eq);
    step();
    i_valid = 1'b0;
  endtask

  // lat counts edges starting with the one that sampled the input strobe as 1.
  task automatic wait_out(output bit found, output int lat);
    found = 1'b0; lat = 1;
    repeat (40) begin
      if (!found) begin
        step(); lat++;
        if (o_valid === 1'b1) found = 1'b1;
      end
    end
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic signed [COEF_WIDTH-1:0] d);
    i_coef_wr = 1'b1; i_coef_addr = a; i_coef_data = d;
    step();
    i_coef_wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_overrun !== 1'b0 ||
        o_inph_data !== '0 || o_quad_data !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%b busy=%b ovr=%b i=%0d q=%0d, required all 0",
               o_valid, o_busy, o_overrun, o_inph_data, o_quad_data);
    end
  endtask

  task automatic test_identity();
    bit found; int lat; logic signed [WIDTH-1:0] ei, eq;
    do_reset();
    send(16'sd1000, -16'sd1000, 16'sd1000, -16'sd1000);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++; $display("FAIL identity_busy: got %b, required 1", o_busy);
    end
    wait_out(found, lat);
    checks++;
    if (!found) begin
      failures++; $display("FAIL identity_timeout: no o_valid within bound");
    end else begin
      ei = exp_i.pop_front(); eq = exp_q.pop_front();
      checks++;
      if (lat !== NTAPS+2) begin
        failures++; $display("FAIL identity_latency: got %0d, required %0d", lat, NTAPS+2);
      end
      checks++;
      if (o_inph_data !== ei || o_quad_data !== eq) begin
        failures++;
        $display("FAIL identity_data: got I=%0d Q=%0d, required I=%0d Q=%0d",
                 o_inph_data, o_quad_data, ei, eq);
      end
      checks++;
      if (o_overrun !== 1'b0) begin
        failures++; $display("FAIL identity_overrun: got %b, required 0", o_overrun);
      end
      step();
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
        failures++;
        $display("FAIL identity_pulse: valid=%b busy=%b one cycle later, required 0 0",
                 o_valid, o_busy);
      end
    end
  endtask

  task automatic test_rounding();
    bit found; int lat; logic signed [WIDTH-1:0] ei, eq;
    do_reset();
    write_coef(0, 18'sd32768);
    send(16'sd3, -16'sd3, 16'sd2, -16'sd1);
    wait_out(found, lat);
    checks++;
    if (!found) begin
      failures++; $display("FAIL rounding_timeout: no o_valid within bound");
    end else begin
      ei = exp_i.pop_front(); eq = exp_q.pop_front();
      checks++;
      if (o_inph_data !== ei || o_quad_data !== eq) begin
        failures++;
        $display("FAIL rounding_data: got I=%0d Q=%0d, required I=%0d Q=%0d",
                 o_inph_data, o_quad_data, ei, eq);
      end
    end
  endtask

  task automatic test_two_tap();
    bit found; int lat; logic signed [WIDTH-1:0] ei, eq;
    do_reset();
    write_coef(0, 18'sd65536);
    write_coef(1, 18'sd65536);
    send(16'sd20000, -16'sd20000, 16'sd20000, -16'sd20000);
    wait_out(found, lat);
    checks++;
    if (!found) begin
      failures++; $display("FAIL two_tap_first_timeout: no o_valid within bound");
    end else begin
      ei = exp_i.pop_front(); eq = exp_q.pop_front();
      checks++;
      if (o_inph_data !== ei || o_quad_data !== eq) begin
        failures++;
        $display("FAIL two_tap_first: got I=%0d Q=%0d, required I=%0d Q=%0d",
                 o_inph_data, o_quad_data, ei, eq);
      end
    end
    step();
`ifdef CIC_COMP_FIR_SATURATE_EN
    send(16'sd20000, -16'sd20000, 16'sd32767, -16'sd32768);
`else
    send(16'sd20000, -16'sd20000, -16'sd25536, 16'sd25536);
`endif
    wait_out(found, lat);
    checks++;
    if (!found) begin
      failures++; $display("FAIL two_tap_limit_timeout: no o_valid within bound");
    end else begin
      ei = exp_i.pop_front(); eq = exp_q.pop_front();
      checks++;
      if (o_inph_data !== ei || o_quad_data !== eq) begin
        failures++;
        $display("FAIL two_tap_limit: got I=%0d Q=%0d, required I=%0d Q=%0d",
                 o_inph_data, o_quad_data, ei, eq);
      end
    end
  endtask

  task automatic test_overrun();
    bit found; int lat; int v0; logic signed [WIDTH-1:0] ei, eq;
    do_reset();
    v0 = vcount;
    send(16'sd1000, 16'sd50, 16'sd1000, 16'sd50);
    step(); step();
    i_inph_data = 16'sd500; i_quad_data = 16'sd500; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    checks++;
    if (o_overrun !== 1'b1) begin
      failures++; $display("FAIL overrun_set: got %b, required 1", o_overrun);
    end
    wait_out(found, lat);
    checks++;
    if (!found) begin
      failures++; $display("FAIL overrun_timeout: no o_valid within bound");
    end else begin
      ei = exp_i.pop_front(); eq = exp_q.pop_front();
      checks++;
      if (o_inph_data !== ei || o_quad_data !== eq) begin
        failures++;
        $display("FAIL overrun_data: got I=%0d Q=%0d, required I=%0d Q=%0d",
                 o_inph_data, o_quad_data, ei, eq);
      end
    end
    repeat (NTAPS+6) step();
    checks++;
    if (vcount - v0 !== 1) begin
      failures++; $display("FAIL overrun_count: got %0d outputs, required 1", vcount - v0);
    end
    send(16'sd42, -16'sd42, 16'sd42, -16'sd42);
    wait_out(found, lat);
    checks++;
    if (!found) begin
      failures++; $display("FAIL overrun_next_timeout: no o_valid within bound");
    end else begin
      ei = exp_i.pop_front(); eq = exp_q.pop_front();
      checks++;
      if (o_inph_data !== ei || o_quad_data !== eq || o_overrun !== 1'b1) begin
        failures++;
        $display("FAIL overrun_sticky: got I=%0d Q=%0d ovr=%b, required I=%0d Q=%0d ovr=1",
                 o_inph_data, o_quad_data, o_overrun, ei, eq);
      end
    end
    do_reset();
    checks++;
    if (o_overrun !== 1'b0) begin
      failures++; $display("FAIL overrun_clear: got %b, required 0", o_overrun);
    end
  endtask

  task automatic test_coef_busy();
    bit found; int lat; logic signed [WIDTH-1:0] ei, eq;
    do_reset();
    send(16'sd300, 16'sd301, 16'sd300, 16'sd301);
    step();
    write_coef(0, '0);
    wait_out(found, lat);
    if (found) begin ei = exp_i.pop_front(); eq = exp_q.pop_front(); end
    step();
    send(16'sd700, -16'sd700, 16'sd700, -16'sd700);
    wait_out(found, lat);
    checks++;
    if (!found) begin
      failures++; $display("FAIL coef_busy_timeout: no o_valid within bound");
    end else begin
      ei = exp_i.pop_front(); eq = exp_q.pop_front();
      checks++;
      if (o_inph_data !== ei || o_quad_data !== eq) begin
        failures++;
        $display("FAIL coef_busy_ignored: got I=%0d Q=%0d, required I=%0d Q=%0d",
                 o_inph_data, o_quad_data, ei, eq);
      end
    end
    step();
    write_coef(0, '0);
    send(16'sd700, -16'sd700, 16'sd0, 16'sd0);
    wait_out(found, lat);
    checks++;
    if (!found) begin
      failures++; $display("FAIL coef_idle_timeout: no o_valid within bound");
    end else begin
      ei = exp_i.pop_front(); eq = exp_q.pop_front();
      checks++;
      if (o_inph_data !== ei || o_quad_data !== eq) begin
        failures++;
        $display("FAIL coef_idle_write: got I=%0d Q=%0d, required I=%0d Q=%0d",
                 o_inph_data, o_quad_data, ei, eq);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found; int lat; int v0; logic signed [WIDTH-1:0] ei, eq;
    do_reset();
    send(16'sd777, -16'sd777, 16'sd777, -16'sd777);
    wait_out(found, lat);
    if (found) begin ei = exp_i.pop_front(); eq = exp_q.pop_front(); end
    step();
    write_coef(0, 18'sd32768);
    v0 = vcount;
    i_inph_data = 16'sd555; i_quad_data = 16'sd555; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (o_inph_data !== '0 || o_quad_data !== '0 || o_valid !== 1'b0 ||
        o_busy !== 1'b0 || o_overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_state: i=%0d q=%0d valid=%b busy=%b ovr=%b, required all 0",
               o_inph_data, o_quad_data, o_valid, o_busy, o_overrun);
    end
    repeat (NTAPS+4) step();
    checks++;
    if (vcount !== v0) begin
      failures++; $display("FAIL reset_mid_no_valid: got %0d outputs, required 0", vcount - v0);
    end
    send(16'sd123, -16'sd123, 16'sd123, -16'sd123);
    wait_out(found, lat);
    checks++;
    if (!found) begin
      failures++; $display("FAIL reset_mid_timeout: no o_valid within bound");
    end else begin
      ei = exp_i.pop_front(); eq = exp_q.pop_front();
      checks++;
      if (o_inph_data !== ei || o_quad_data !== eq) begin
        failures++;
        $display("FAIL reset_mid_identity: got I=%0d Q=%0d, required I=%0d Q=%0d",
                 o_inph_data, o_quad_data, ei, eq);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0; i_inph_data = '0; i_quad_data = '0;
    i_coef_wr = 1'b0; i_coef_addr = '0; i_coef_data = '0;
    test_reset();
    test_identity();
    test_rounding();
    test_two_tap();
    test_overrun();
    test_coef_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
